sdram_port_arbiter: RTL and testbench

Shares the single SDRAM controller port on the Poseidon EP4CGX150 board between three requesters: the video scanout fetcher, the guest CPU, and the data_io (SPI_SS2) ROM/disk loader. It sits inside guest_top between the requesters and the SDRAM command sequencer, which drives the SDRAM_* pins. One transaction is in flight at a time. A watchdog keeps a requester from hanging if the sequencer never answers.

---
 rtl/sdram_port_arbiter_if.sv | 48 ++++
 rtl/sdram_port_arbiter.sv | 108 ++++++++++
 tb/tb_sdram_port_arbiter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Requester/sequencer bundle for the SDRAM port arbiter.
// The arbiter takes the slave view; requesters and the sequencer take the master view.
interface sdram_port_arbiter_if #(
   parameter int AW = 24,
   parameter int DW = 16
);
   logic          vid_req;
   logic          cpu_req;
   logic          io_req;
   logic [AW-1:0] vid_addr;
   logic [AW-1:0] cpu_addr;
   logic [AW-1:0] io_addr;
   logic          cpu_we;
   logic          io_we;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] io_wdata;
   logic [1:0]    cpu_be;
   logic [1:0]    io_be;
   logic          vid_ack;
   logic          cpu_ack;
   logic          io_ack;
   logic [DW-1:0] rdata;
   logic          err;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [1:0]    mem_dqm;
   logic          mem_done;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   modport slave (
      input  vid_req, cpu_req, io_req, vid_addr, cpu_addr, io_addr,
      input  cpu_we, io_we, cpu_wdata, io_wdata, cpu_be, io_be,
      input  mem_done, mem_rdata,
      output vid_ack, cpu_ack, io_ack, rdata, err, busy,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_dqm
   );

   modport master (
      output vid_req, cpu_req, io_req, vid_addr, cpu_addr, io_addr,
      output cpu_we, io_we, cpu_wdata, io_wdata, cpu_be, io_be,
      output mem_done, mem_rdata,
      input  vid_ack, cpu_ack, io_ack, rdata, err, busy,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_dqm
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter (video, CPU, data_io) in front of the SDRAM command sequencer,
// one transaction in flight, with a watchdog that forces an error completion.
//
// state   | meaning
// S_IDLE  | sample requests, latch the winner's command
// S_ISSUE | one-cycle mem_req strobe to the sequencer
// S_WAIT  | wait for mem_done, watchdog counting
// S_DONE  | winner's ack pulse, round-robin update already applied
module sdram_port_arbiter #(
   parameter int AW      = 24,
   parameter int DW      = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                clk_sys,
   input  logic                reset,
   sdram_port_arbiter_if.slave bus
);
   localparam int              CW      = $clog2(TIMEOUT);
   localparam logic [CW-1:0]   WD_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {ID_VID, ID_CPU, ID_IO} id_t;

   state_t        state;
   id_t           cmd_id;
   logic          rr_io;
   logic [CW-1:0] wd_cnt;
   logic          grant_cpu;

   // CPU wins when it is the only one of the pair pending, or when rr prefers it.
   assign grant_cpu = bus.cpu_req && (!bus.io_req || !rr_io);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         cmd_id        <= ID_VID;
         rr_io         <= 1'b0;
         wd_cnt        <= '0;
         bus.vid_ack   <= 1'b0;
         bus.cpu_ack   <= 1'b0;
         bus.io_ack    <= 1'b0;
         bus.rdata     <= {DW{1'b0}};
         bus.err       <= 1'b0;
         bus.busy      <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= {AW{1'b0}};
         bus.mem_wdata <= {DW{1'b0}};
         bus.mem_dqm   <= 2'b00;
      end else begin
         bus.vid_ack <= 1'b0;
         bus.cpu_ack <= 1'b0;
         bus.io_ack  <= 1'b0;
         bus.mem_req <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.vid_req) begin
                  cmd_id        <= ID_VID;
                  bus.mem_we    <= 1'b0;
                  bus.mem_addr  <= bus.vid_addr;
                  bus.mem_wdata <= {DW{1'b0}};
                  bus.mem_dqm   <= 2'b00;
               end else if (grant_cpu) begin
                  cmd_id        <= ID_CPU;
                  bus.mem_we    <= bus.cpu_we;
                  bus.mem_addr  <= bus.cpu_addr;
                  bus.mem_wdata <= bus.cpu_wdata;
                  bus.mem_dqm   <= bus.cpu_we ? ~bus.cpu_be : 2'b00;
               end else if (bus.io_req) begin
                  cmd_id        <= ID_IO;
                  bus.mem_we    <= bus.io_we;
                  bus.mem_addr  <= bus.io_addr;
                  bus.mem_wdata <= bus.io_wdata;
                  bus.mem_dqm   <= bus.io_we ? ~bus.io_be : 2'b00;
               end
               if (bus.vid_req || bus.cpu_req || bus.io_req) begin
                  state       <= S_ISSUE;
                  bus.mem_req <= 1'b1;
                  bus.busy    <= 1'b1;
               end
            end
            S_ISSUE: begin
               state  <= S_WAIT;
               wd_cnt <= '0;
            end
            S_WAIT: begin
               if (bus.mem_done || wd_cnt == WD_LAST) begin
                  state       <= S_DONE;
                  bus.rdata   <= bus.mem_done ? bus.mem_rdata : {DW{1'b1}};
                  bus.err     <= !bus.mem_done;
                  bus.vid_ack <= (cmd_id == ID_VID);
                  bus.cpu_ack <= (cmd_id == ID_CPU);
                  bus.io_ack  <= (cmd_id == ID_IO);
                  if (cmd_id != ID_VID)
                     rr_io <= (cmd_id == ID_CPU);
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            S_DONE: begin
               state    <= S_IDLE;
               bus.busy <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the priority / round-robin rules.
module tb_sdram_port_arbiter;
   logic clk_sys = 1'b0;
   logic reset   = 1'b0;

   sdram_port_arbiter_if #(.AW(24), .DW(16)) bus ();
   sdram_port_arbiter #(.AW(24), .DW(16), .TIMEOUT(64)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   bit          seq_en = 1'b1;
   int          seq_lat = 1;
   int          seq_cnt = 0;
   logic [15:0] seq_data = 16'h0000;
   int          ack_cnt [3];
   int          last_ack_id;
   int          last_ack_cyc;
   logic [15:0] last_rdata;
   logic        last_err;
   int          hold [3];
   bit          rereq = 1'b0;
   logic [23:0] grants [$];
   logic [23:0] c_addr [3];
   logic        c_we [3];
   logic [15:0] c_wdata [3];
   logic [1:0]  c_be [3];

   task automatic set_cmd(input int r, input logic [23:0] a, input logic we,
                          input logic [15:0] wd, input logic [1:0] be);
      c_addr[r] = a; c_we[r] = (r == 0) ? 1'b0 : we; c_wdata[r] = wd; c_be[r] = be;
      case (r)
         0: bus.vid_addr = a;
         1: begin bus.cpu_addr = a; bus.cpu_we = we; bus.cpu_wdata = wd; bus.cpu_be = be; end
         default: begin bus.io_addr = a; bus.io_we = we; bus.io_wdata = wd; bus.io_be = be; end
      endcase
   endtask

   task automatic set_req(input int r, input logic v);
      case (r)
         0: bus.vid_req = v;
         1: bus.cpu_req = v;
         default: bus.io_req = v;
      endcase
   endtask

   function automatic logic get_req(input int r);
      case (r)
         0: return bus.vid_req;
         1: return bus.cpu_req;
         default: return bus.io_req;
      endcase
   endfunction

   function automatic logic get_ack(input int r);
      case (r)
         0: return bus.vid_ack === 1'b1;
         1: return bus.cpu_ack === 1'b1;
         default: return bus.io_ack === 1'b1;
      endcase
   endfunction

   function automatic logic [64:0] out_vec();
      return {bus.vid_ack, bus.cpu_ack, bus.io_ack, bus.mem_req, bus.mem_we, bus.err, bus.busy,
              bus.mem_addr, bus.mem_wdata, bus.mem_dqm, bus.rdata};
   endfunction

   function automatic int ack_total();
      return ack_cnt[0] + ack_cnt[1] + ack_cnt[2];
   endfunction

   // One clock: sequencer model responds L cycles after mem_req; requesters drop on ack
   task automatic step();
      @(posedge clk_sys);
      #1;
      cyc++;
      bus.mem_done = 1'b0;
      if (seq_cnt > 0) begin
         seq_cnt--;
         if (seq_cnt == 0) begin
            bus.mem_done  = 1'b1;
            bus.mem_rdata = seq_data;
         end
      end
      if (bus.mem_req === 1'b1) begin
         if (seq_en) seq_cnt = seq_lat;
         grants.push_back(bus.mem_addr);
      end
      for (int r = 0; r < 3; r++) begin
         if (hold[r] > 0) begin
            hold[r]--;
            if (hold[r] == 0 && rereq) set_req(r, 1'b1);
         end
      end
      for (int r = 0; r < 3; r++) begin
         if (get_ack(r)) begin
            ack_cnt[r]++;
            last_ack_id  = r;
            last_ack_cyc = cyc;
            last_rdata   = bus.rdata;
            last_err     = bus.err;
            set_req(r, 1'b0);
            hold[r] = 2;
         end
      end
   endtask

   task automatic wait_ack(input int bound, output bit ok);
      last_ack_id = -1;
      for (int i = 0; i < bound; i++) begin
         step();
         if (last_ack_id >= 0) break;
      end
      ok = (last_ack_id >= 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int r = 0; r < 3; r++) begin
         set_req(r, 1'b0);
         set_cmd(r, 24'h0, 1'b0, 16'h0, 2'b00);
         hold[r] = 0;
      end
      bus.mem_done = 1'b0; bus.mem_rdata = 16'h0;
      seq_cnt = 0; seq_en = 1'b1; rereq = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      step();
      cyc = 0;
   endtask

   task automatic test_reset();
      for (int r = 0; r < 3; r++) begin
         set_req(r, 1'b0); set_cmd(r, 24'h0, 1'b0, 16'h0, 2'b00); hold[r] = 0; ack_cnt[r] = 0;
      end
      bus.mem_done = 1'b0; bus.mem_rdata = 16'h0;
      #2 reset = 1'b1;
      #1;
      tests++;
      if (out_vec() !== 65'd0) begin
         fails++; $display("FAIL reset_async: outputs=%h expected 0", out_vec());
      end
      step(); step();
      reset = 1'b0;
      repeat (4) step();
      tests++;
      if (out_vec() !== 65'd0) begin
         fails++; $display("FAIL reset_idle: outputs=%h expected 0", out_vec());
      end
   endtask

   task automatic test_cpu_write();
      bit ok;
      do_reset();
      seq_lat = 3;
      set_cmd(1, 24'h123456, 1'b1, 16'hBEEF, 2'b10);
      set_req(1, 1'b1);
      cyc = 0;
      step();
      tests++;
      if ({bus.mem_req, bus.mem_we, bus.mem_dqm, bus.busy} !== 5'b11011) begin
         fails++; $display("FAIL cpu_write_issue: req/we/dqm/busy=%b expected 11011",
                           {bus.mem_req, bus.mem_we, bus.mem_dqm, bus.busy});
      end
      tests++;
      if ({bus.mem_addr, bus.mem_wdata} !== {24'h123456, 16'hBEEF}) begin
         fails++; $display("FAIL cpu_write_cmd: addr/wdata=%h expected 123456beef",
                           {bus.mem_addr, bus.mem_wdata});
      end
      step();
      tests++;
      if (bus.mem_req !== 1'b0) begin
         fails++; $display("FAIL cpu_write_strobe_len: mem_req=%b expected 0", bus.mem_req);
      end
      wait_ack(20, ok);
      tests++;
      if (!ok || last_ack_id != 1 || last_ack_cyc != 5 || last_err !== 1'b0) begin
         fails++; $display("FAIL cpu_write_ack: id=%0d cycle=%0d err=%b expected id 1 cycle 5 err 0",
                           last_ack_id, last_ack_cyc, last_err);
      end
      step();
      tests++;
      if (bus.busy !== 1'b0) begin
         fails++; $display("FAIL cpu_write_busy_clear: busy=%b expected 0", bus.busy);
      end
   endtask

   task automatic test_video_read();
      bit ok;
      int c0, i0;
      do_reset();
      c0 = ack_cnt[1]; i0 = ack_cnt[2];
      seq_lat = 1; seq_data = 16'h5A5A;
      set_cmd(0, 24'h00ABCD, 1'b0, 16'h0, 2'b00);
      set_req(0, 1'b1);
      cyc = 0;
      step();
      tests++;
      if ({bus.mem_req, bus.mem_we, bus.mem_dqm, bus.mem_addr} !== {1'b1, 1'b0, 2'b00, 24'h00ABCD}) begin
         fails++; $display("FAIL video_issue: req/we/dqm/addr=%h expected 200abcd-form",
                           {bus.mem_req, bus.mem_we, bus.mem_dqm, bus.mem_addr});
      end
      wait_ack(20, ok);
      tests++;
      if (!ok || last_ack_id != 0 || last_ack_cyc != 3 || last_rdata !== 16'h5A5A) begin
         fails++; $display("FAIL video_ack: id=%0d cycle=%0d rdata=%h expected id 0 cycle 3 rdata 5a5a",
                           last_ack_id, last_ack_cyc, last_rdata);
      end
      repeat (4) step();
      tests++;
      if (ack_cnt[1] != c0 || ack_cnt[2] != i0) begin
         fails++; $display("FAIL video_no_other_ack: cpu/io acks=%0d/%0d expected %0d/%0d",
                           ack_cnt[1], ack_cnt[2], c0, i0);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      do_reset();
      seq_en = 1'b0;
      set_cmd(2, 24'hFEDCBA, 1'b0, 16'h0, 2'b11);
      set_req(2, 1'b1);
      cyc = 0;
      wait_ack(100, ok);
      tests++;
      if (!ok || last_ack_id != 2 || last_ack_cyc != 66 || last_err !== 1'b1 || last_rdata !== 16'hFFFF) begin
         fails++; $display("FAIL timeout_ack: id=%0d cycle=%0d err=%b rdata=%h expected id 2 cycle 66 err 1 rdata ffff",
                           last_ack_id, last_ack_cyc, last_err, last_rdata);
      end
      step();
      seq_en = 1'b1; seq_lat = 2; seq_data = 16'h1234;
      set_cmd(2, 24'h000777, 1'b1, 16'h0077, 2'b01);
      set_req(2, 1'b1);
      cyc = 0;
      wait_ack(20, ok);
      tests++;
      if (!ok || last_ack_id != 2 || last_ack_cyc != 4 || last_err !== 1'b0 || last_rdata !== 16'h1234) begin
         fails++; $display("FAIL timeout_recover: id=%0d cycle=%0d err=%b rdata=%h expected id 2 cycle 4 err 0 rdata 1234",
                           last_ack_id, last_ack_cyc, last_err, last_rdata);
      end
   endtask

   task automatic test_all_three();
      int exp_order [8] = '{0, 1, 0, 2, 0, 1, 0, 2};
      int got;
      do_reset();
      seq_lat = 1;
      set_cmd(0, 24'h100000, 1'b0, 16'h0, 2'b00);
      set_cmd(1, 24'h200000, 1'b0, 16'h0, 2'b00);
      set_cmd(2, 24'h300000, 1'b0, 16'h0, 2'b00);
      grants.delete();
      rereq = 1'b1;
      for (int r = 0; r < 3; r++) set_req(r, 1'b1);
      for (int i = 0; i < 300 && grants.size() < 8; i++) step();
      tests++;
      if (grants.size() < 8) begin
         fails++; $display("FAIL all_three_count: grants=%0d expected 8", grants.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            got = -1;
            for (int r = 0; r < 3; r++) if (grants[i] == c_addr[r]) got = r;
            tests++;
            if (got != exp_order[i]) begin
               fails++; $display("FAIL all_three_order[%0d]: granted %0d expected %0d", i, got, exp_order[i]);
            end
         end
      end
      rereq = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      bit ok;
      int a0;
      do_reset();
      seq_lat = 2;
      set_cmd(1, 24'h000111, 1'b0, 16'h0, 2'b00);
      set_req(1, 1'b1);
      wait_ack(20, ok);
      step(); step();
      seq_en = 1'b0;
      set_cmd(1, 24'h000222, 1'b1, 16'hAAAA, 2'b11);
      set_req(1, 1'b1);
      repeat (3) step();
      a0 = ack_total();
      #2 reset = 1'b1;
      #1;
      tests++;
      if (out_vec() !== 65'd0) begin
         fails++; $display("FAIL reset_wait_async: outputs=%h expected 0", out_vec());
      end
      for (int r = 0; r < 3; r++) set_req(r, 1'b0);
      seq_cnt = 0;
      step(); step();
      reset = 1'b0;
      step();
      tests++;
      if (ack_total() != a0 || bus.busy !== 1'b0) begin
         fails++; $display("FAIL reset_wait_no_ack: acks=%0d busy=%b expected %0d 0", ack_total(), bus.busy, a0);
      end
      seq_en = 1'b1; seq_lat = 1; seq_data = 16'h3C3C;
      set_cmd(1, 24'h000333, 1'b0, 16'h0, 2'b00);
      set_cmd(2, 24'h000444, 1'b0, 16'h0, 2'b00);
      set_req(1, 1'b1); set_req(2, 1'b1);
      cyc = 0;
      step();
      tests++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 24'h000333) begin
         fails++; $display("FAIL reset_wait_rr: mem_req=%b addr=%h expected 1 000333", bus.mem_req, bus.mem_addr);
      end
      wait_ack(20, ok);
      tests++;
      if (!ok || last_ack_id != 1 || last_ack_cyc != 3 || last_rdata !== 16'h3C3C) begin
         fails++; $display("FAIL reset_wait_fresh: id=%0d cycle=%0d rdata=%h expected id 1 cycle 3 rdata 3c3c",
                           last_ack_id, last_ack_cyc, last_rdata);
      end
      wait_ack(20, ok);
      tests++;
      if (!ok || last_ack_id != 2) begin
         fails++; $display("FAIL reset_wait_io_pending: id=%0d expected 2", last_ack_id);
      end
   endtask

   task automatic test_spurious_done();
      bit ok;
      int a0;
      do_reset();
      seq_en = 1'b0;
      a0 = ack_total();
      bus.mem_done = 1'b1; bus.mem_rdata = 16'hDEAD;
      step(); step();
      tests++;
      if (ack_total() != a0 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
         fails++; $display("FAIL spurious_idle_before: acks=%0d busy=%b req=%b expected %0d 0 0",
                           ack_total(), bus.busy, bus.mem_req, a0);
      end
      set_cmd(1, 24'h0ABCDE, 1'b1, 16'h5555, 2'b01);
      set_req(1, 1'b1);
      cyc = 0;
      step();
      bus.mem_done = 1'b1; bus.mem_rdata = 16'hBAD0;
      repeat (4) step();
      tests++;
      if (ack_total() != a0 || bus.busy !== 1'b1) begin
         fails++; $display("FAIL spurious_issue: acks=%0d busy=%b expected %0d 1", ack_total(), bus.busy, a0);
      end
      bus.mem_done = 1'b1; bus.mem_rdata = 16'hC0DE;
      wait_ack(20, ok);
      tests++;
      if (!ok || last_ack_id != 1 || last_ack_cyc != 6 || last_rdata !== 16'hC0DE || last_err !== 1'b0) begin
         fails++; $display("FAIL spurious_wait_done: id=%0d cycle=%0d rdata=%h err=%b expected id 1 cycle 6 rdata c0de err 0",
                           last_ack_id, last_ack_cyc, last_rdata, last_err);
      end
      step();
      a0 = ack_total();
      bus.mem_done = 1'b1; bus.mem_rdata = 16'hDEAD;
      repeat (5) step();
      tests++;
      if (ack_total() != a0 || bus.busy !== 1'b0) begin
         fails++; $display("FAIL spurious_idle_after: acks=%0d busy=%b expected %0d 0", ack_total(), bus.busy, a0);
      end
   endtask

   task automatic test_random();
      int          n [3];
      bit          idle_p, ack_p, idle_c, ack_c, exp_mreq, rr_io;
      logic [2:0]  prev_req, obs, expv;
      int          win, exp_cyc;
      logic [15:0] exp_rd;
      do_reset();
      n[0] = 25; n[1] = 30; n[2] = 30;
      idle_p = 1'b1; ack_p = 1'b0; prev_req = 3'b000; rr_io = 1'b0;
      win = -1; exp_cyc = -1; exp_rd = 16'h0;
      seq_lat = $urandom_range(1, 6);
      for (int k = 0; k < 20000; k++) begin
         if (n[0] + n[1] + n[2] == 0 && win < 0 && prev_req == 3'b000) break;
         step();
         exp_mreq = idle_p && (prev_req != 3'b000);
         idle_c   = ack_p || (idle_p && prev_req == 3'b000);
         ack_c    = 1'b0;
         tests++;
         if (bus.mem_req !== exp_mreq) begin
            fails++; $display("FAIL rand_mem_req @%0d: got %b expected %b", cyc, bus.mem_req, exp_mreq);
         end
         if (exp_mreq) begin
            if (prev_req[0]) win = 0;
            else if (prev_req[1] && (!prev_req[2] || !rr_io)) win = 1;
            else win = 2;
            tests++;
            if (bus.mem_addr !== c_addr[win] || bus.mem_we !== c_we[win] ||
                bus.mem_dqm !== (c_we[win] ? ~c_be[win] : 2'b00) ||
                (c_we[win] && bus.mem_wdata !== c_wdata[win])) begin
               fails++; $display("FAIL rand_cmd @%0d: addr=%h we=%b dqm=%b wdata=%h expected requester %0d addr=%h",
                                 cyc, bus.mem_addr, bus.mem_we, bus.mem_dqm, bus.mem_wdata, win, c_addr[win]);
            end
            exp_cyc  = cyc + seq_lat + 1;
            seq_data = 16'($urandom);
            exp_rd   = seq_data;
         end
         obs  = {get_ack(2), get_ack(1), get_ack(0)};
         expv = (win >= 0 && cyc == exp_cyc) ? (3'b001 << win) : 3'b000;
         tests++;
         if (obs !== expv) begin
            fails++; $display("FAIL rand_ack @%0d: got %b expected %b", cyc, obs, expv);
         end
         if (expv != 3'b000) begin
            tests++;
            if (bus.rdata !== exp_rd || bus.err !== 1'b0) begin
               fails++; $display("FAIL rand_rdata @%0d: rdata=%h err=%b expected %h 0", cyc, bus.rdata, bus.err, exp_rd);
            end
            if (win != 0) rr_io = (win == 1);
            win = -1; ack_c = 1'b1;
            seq_lat = $urandom_range(1, 6);
         end
         for (int r = 0; r < 3; r++) begin
            if (!get_req(r) && hold[r] == 0 && n[r] > 0 && $urandom_range(0, 3) == 0) begin
               set_cmd(r, 24'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)));
               set_req(r, 1'b1);
               n[r]--;
            end
         end
         prev_req = {get_req(2), get_req(1), get_req(0)};
         idle_p = idle_c; ack_p = ack_c;
      end
      tests++;
      if (n[0] + n[1] + n[2] != 0 || win >= 0 || prev_req != 3'b000) begin
         fails++; $display("FAIL rand_drain: remaining=%0d in_flight=%0d pending=%b expected 0 -1 000",
                           n[0] + n[1] + n[2], win, prev_req);
      end
   endtask

   initial begin
      test_reset();
      test_cpu_write();
      test_video_read();
      test_timeout();
      test_all_three();
      test_reset_in_wait();
      test_spurious_done();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
